// File: rtl/pid_pwm_stage.sv
// PWM output stage for the PID loop: scales and clamps the control word into a
// shadowed duty register and drives a complementary gate pair with dead time.
module pid_pwm_stage #(
    parameter int PWM_BITS   = 10,
    parameter int FRAC_SHIFT = 16,
    parameter int DEAD       = 4,
    parameter int PERIOD_RST = 100
) (
    input  logic                clk,
    input  logic                arst,
    input  logic                srst,
    input  logic                en,
    input  logic signed [31:0]  control,
    input  logic [PWM_BITS-1:0] period,
    output logic                pwm_hi,
    output logic                pwm_lo,
    output logic [PWM_BITS-1:0] duty,
    output logic                sat_hi,
    output logic                sat_lo,
    output logic                period_tick
);
    localparam int                  DT_W    = (DEAD > 1) ? $clog2(DEAD) : 1;
    localparam logic [DT_W-1:0]     DT_LAST = DT_W'((DEAD > 0) ? DEAD - 1 : 0);
    localparam logic [DT_W-1:0]     DT_ONE  = DT_W'(1);
    localparam logic [PWM_BITS-1:0] P_MIN   = PWM_BITS'(2);
    localparam logic [PWM_BITS-1:0] P_ONE   = PWM_BITS'(1);

    typedef enum logic [1:0] {LO, DT_HI, HI, DT_LO} state_t;

    logic [PWM_BITS-1:0] cnt, period_sh, pe, pe_next;
    logic signed [31:0]  d_val, pe_next_s;
    logic                load, raw;
    state_t              state, state_nx;
    logic [DT_W-1:0]     dt_cnt, dt_nx;
    logic                arm, arm_nx;

    assign pe          = (period_sh < P_MIN) ? P_MIN : period_sh;
    assign pe_next     = (period < P_MIN) ? P_MIN : period;
    assign pe_next_s   = signed'(32'(pe_next));
    assign d_val       = control >>> FRAC_SHIFT;
    assign load        = en && (cnt == pe - P_ONE);
    assign raw         = (cnt < duty);
    assign period_tick = load;
    assign pwm_hi      = (state == HI);
    assign pwm_lo      = (state == LO);

    // NOTE: every state register is written with <= so all flops sample together.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            cnt       <= '0;
            duty      <= '0;
            sat_hi    <= 1'b0;
            sat_lo    <= 1'b0;
            period_sh <= PWM_BITS'(PERIOD_RST);
            state     <= DT_LO;
            dt_cnt    <= '0;
            arm       <= 1'b1;
        end else if (!srst) begin
            cnt       <= '0;
            duty      <= '0;
            sat_hi    <= 1'b0;
            sat_lo    <= 1'b0;
            period_sh <= PWM_BITS'(PERIOD_RST);
            state     <= DT_LO;
            dt_cnt    <= '0;
            arm       <= 1'b1;
        end else begin
            state  <= state_nx;
            dt_cnt <= dt_nx;
            arm    <= arm_nx;
            if (en) cnt <= load ? '0 : cnt + P_ONE;
            if (load) begin
                period_sh <= period;
                if (d_val < 0) begin
                    duty   <= '0;
                    sat_hi <= 1'b0;
                    sat_lo <= 1'b1;
                end else if (d_val > pe_next_s) begin
                    duty   <= pe_next;
                    sat_hi <= 1'b1;
                    sat_lo <= 1'b0;
                end else begin
                    duty   <= d_val[PWM_BITS-1:0];
                    sat_hi <= 1'b0;
                    sat_lo <= 1'b0;
                end
            end
        end
    end

    // arm marks a DT_LO entered from reset or disable: it always serves the full
    // dead time before either side may rise, instead of aborting back to HI.
    // NOTE: defaults first, so no path through this block can infer a latch.
    always_comb begin
        state_nx = state;
        dt_nx    = dt_cnt;
        arm_nx   = arm;
        if (!en) begin
            state_nx = DT_LO;
            dt_nx    = '0;
            arm_nx   = 1'b1;
        end else begin
            case (state)
                LO: if (raw) begin
                    state_nx = (DEAD == 0) ? HI : DT_HI;
                    dt_nx    = '0;
                end
                DT_HI: begin
                    if (!raw)                   state_nx = LO;
                    else if (dt_cnt == DT_LAST) state_nx = HI;
                    else                        dt_nx    = dt_cnt + DT_ONE;
                end
                HI: if (!raw) begin
                    state_nx = (DEAD == 0) ? LO : DT_LO;
                    dt_nx    = '0;
                end
                DT_LO: begin
                    if (arm) begin
                        if (dt_cnt == DT_LAST) begin
                            state_nx = raw ? HI : LO;
                            arm_nx   = 1'b0;
                        end else begin
                            dt_nx = dt_cnt + DT_ONE;
                        end
                    end else if (raw)           state_nx = HI;
                    else if (dt_cnt == DT_LAST) state_nx = LO;
                    else                        dt_nx    = dt_cnt + DT_ONE;
                end
                default: begin
                    state_nx = DT_LO;
                    dt_nx    = '0;
                    arm_nx   = 1'b1;
                end
            endcase
        end
    end
endmodule
